mem_rw_ctrl: RTL
================

MEM_RW_CTRL -- requirements
Module: mem_rw_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 8, number of words (2..256); need not be a power of two.
REQ-003 Parameter INIT_BASE, default 8'h10, seed of the power-up fill pattern.
REQ-004 Local parameter ADDR_W SHALL equal $clog2(DEPTH).
REQ-005 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port enable  input  1  request valid.
REQ-008 Port read  input  1  read request qualifier.
REQ-009 Port write  input  1  write request qualifier.
REQ-010 Port address  input  ADDR_W  word address.
REQ-011 Port wdata  input  DATA_W  write data.
REQ-012 Port ready  output  1  block can accept a request this cycle.
REQ-013 Port rdata  output  DATA_W  read data.
REQ-014 Port rvalid  output  1  one-cycle pulse, rdata valid.
REQ-015 Port err  output  1  one-cycle pulse, rejected request.

Function
REQ-016 FSM SHALL have two states, INIT and IDLE; reset enters INIT.
REQ-017 INIT SHALL write word i = (INIT_BASE + i) truncated to DATA_W, one word per cycle, i = 0..DEPTH-1, using an internal fill counter.
REQ-018 INIT SHALL last exactly DEPTH cycles; INIT -> IDLE after word DEPTH-1 is written; ready = 0 throughout INIT.
REQ-019 ready SHALL be 1 in IDLE.
REQ-020 A request is accepted iff enable && ready at a rising edge; while ready = 0, enable is ignored with no err.
REQ-021 Accepted read, address < DEPTH: rdata = mem[address] and rvalid = 1 in the next cycle (latency 1).
REQ-022 Accepted write, address < DEPTH: mem[address] <= wdata at that edge; no rvalid.
REQ-023 A read of the same address in the following cycle SHALL return the newly written data.
REQ-024 address >= DEPTH: no memory change; err = 1 next cycle; for a read also rvalid = 1 with rdata = 0.
REQ-025 read && write both 1: no access; err = 1 next cycle; rvalid = 0.
REQ-026 read = write = 0 with enable = 1: no-op; no pulse.
REQ-027 rdata SHALL hold its last value when rvalid = 0.
REQ-028 Back-to-back requests SHALL be accepted every cycle in IDLE (full throughput).

Reset
REQ-029 On rst: ready = 0, rvalid = 0, err = 0, rdata = 0, fill counter = 0, state = INIT.
REQ-030 rst asserted mid-INIT or mid-traffic SHALL restart INIT from word 0; pending responses are dropped.
REQ-031 rst has priority over any simultaneous request.

Configuration
REQ-032 Macro MEM_RW_CTRL_TRACE_EN defined: each accepted access emits one simulation $display line with operation, address, data and err status; INIT completion emits one line.
REQ-033 Macro MEM_RW_CTRL_TRACE_EN undefined: no display code is compiled; cycle behaviour is identical.

Structure
REQ-034 Package mem_rw_ctrl_pkg SHALL hold the state enum typedef (ST_INIT, ST_IDLE) and the op-decode typedef (OP_NONE, OP_RD, OP_WR, OP_BAD).
REQ-035 Storage SHALL live in sub-module mem_rw_ctrl_ram (1 write port, 1 synchronous read port, parameterised DATA_W/DEPTH); FSM and decode stay in mem_rw_ctrl.

Verification (defaults DATA_W=8, DEPTH=8, INIT_BASE=8'h10)
REQ-036 Release rst -> ready rises exactly 8 cycles later; reads of 0..7 return 0x10..0x17, each rvalid one cycle after the request.
REQ-037 Write 0xA5 to addr 3, then read addr 3 in the next cycle -> rdata 0xA5 with rvalid; addr 2 still 0x12.
REQ-038 DEPTH=6, read addr 7 -> rvalid = 1, rdata = 0, err = 1; write addr 6 -> err = 1, memory unchanged.
REQ-039 enable with read = write = 1 at addr 0 -> err = 1, rvalid = 0, word 0 unchanged (0x10).
REQ-040 Write 0x55 to addr 1, assert rst at INIT cycle 4, release -> ready after 8 more cycles; addr 1 reads 0x11.
REQ-041 Request issued during INIT -> ignored; no err, no rvalid, fill pattern intact.

Source files
------------

// File: rtl/mem_rw_ctrl_pkg.sv
// Shared types for the mem_rw_ctrl block: FSM state encoding, request
// decode classes and the decode helper used by the controller.
package mem_rw_ctrl_pkg;

   // Controller states: power-up fill, then request service.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   // Request class derived from the read/write qualifiers.
   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_RD   = 2'd1,
      OP_WR   = 2'd2,
      OP_BAD  = 2'd3
   } op_t;

   // Both qualifiers set is contradictory and reported as an error.
   function automatic op_t decode_op(input logic rd, input logic wr);
      op_t op;
      unique case ({rd, wr})
         2'b10:   op = OP_RD;
         2'b01:   op = OP_WR;
         2'b11:   op = OP_BAD;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mem_rw_ctrl_ram.sv
// Single write port, single synchronous read port word storage.
// The read register can be cleared so the controller can return zero
// for reset and for out-of-range reads; otherwise it holds its value.
module mem_rw_ctrl_ram #(
   parameter int  DATA_W = 8,
   parameter int  DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic              i_rclr,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port.
   // NOTE: the array has no reset; the controller's fill sequence gives it
   // defined contents, and a reset term would prevent RAM inference.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Synchronous read port; holds the last word unless cleared or re-read.
   // NOTE: non-blocking assignment keeps every flop updating from pre-edge
   // values, so ordering between always_ff blocks never matters.
   always_ff @(posedge clk) begin
      if (i_rclr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_rw_ctrl.sv
// Memory read/write controller: fills storage with INIT_BASE+i after reset,
// then services one read or write request per cycle with 1-cycle read
// latency and error pulses for out-of-range or contradictory requests.
// Optional macro MEM_RW_CTRL_TRACE_EN adds simulation trace lines.
module mem_rw_ctrl
   import mem_rw_ctrl_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter int          DEPTH     = 8,
   parameter logic [63:0] INIT_BASE = 64'h10,
   localparam int         ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              err
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_fill;
   logic              r_ready;
   logic              r_rvalid;
   logic              r_err;

   op_t               w_op;
   logic              w_in_range;
   logic              w_accept;
   logic              w_fill_last;
   logic [DATA_W-1:0] w_fill_data;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_re;
   logic              w_rclr;

   // Request decode; ready is only high in IDLE and reset overrides requests.
   always_comb begin
      w_op        = decode_op(read, write);
      w_in_range  = ({1'b0, address} < DEPTH_C);
      w_accept    = enable && r_ready && !rst;
      w_fill_last = (r_fill == LAST_C);
      w_fill_data = DATA_W'(INIT_BASE + 64'(r_fill));
   end

   // Storage port steering: fill pattern during INIT, accepted requests in IDLE.
   // NOTE: every output gets a default first so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = address;
      w_wdata = wdata;
      w_re    = 1'b0;
      w_rclr  = rst;
      if (!rst) begin
         if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_fill;
            w_wdata = w_fill_data;
         end else if (w_accept) begin
            w_we   = (w_op == OP_WR) && w_in_range;
            w_re   = (w_op == OP_RD) && w_in_range;
            w_rclr = (w_op == OP_RD) && !w_in_range;
         end
      end
   end

   // Controller FSM with registered ready/rvalid/err outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_INIT;
         r_fill   <= '0;
         r_ready  <= 1'b0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         unique case (r_state)
            ST_INIT: begin
               if (w_fill_last) begin
                  r_fill  <= '0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_fill <= r_fill + 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_rvalid <= (w_op == OP_RD);
                  r_err    <= (w_op == OP_BAD) ||
                              (((w_op == OP_RD) || (w_op == OP_WR)) && !w_in_range);
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   mem_rw_ctrl_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_rclr  (w_rclr),
      .i_raddr (address),
      .o_rdata (rdata)
   );

   assign ready  = r_ready;
   assign rvalid = r_rvalid;
   assign err    = r_err;

`ifdef MEM_RW_CTRL_TRACE_EN
   op_t               r_tr_op;
   logic              r_tr_vld;
   logic [ADDR_W-1:0] r_tr_addr;
   logic [DATA_W-1:0] r_tr_wdata;

   // Capture each accepted access so its line can show the read data and err.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tr_vld <= 1'b0;
      end else begin
         r_tr_vld   <= w_accept && (w_op != OP_NONE);
         r_tr_op    <= w_op;
         r_tr_addr  <= address;
         r_tr_wdata <= wdata;
      end
   end

   // Emit one trace line per accepted access and one at fill completion.
   always_ff @(posedge clk) begin
      if (!rst && r_tr_vld) begin
         $display("mem_rw_ctrl: %s addr=%0d data=%h err=%0b", r_tr_op.name(), r_tr_addr,
                  (r_tr_op == OP_WR) ? r_tr_wdata : rdata, r_err);
      end
      if (!rst && (r_state == ST_INIT) && w_fill_last) begin
         $display("mem_rw_ctrl: init complete, %0d words", DEPTH);
      end
   end
`endif

endmodule
